// File: rtl/run_scan_checker.sv
// Run-then-verify controller: runs the CPU for num_cycles clocks, then scans regfile port A against an expected ROM.
// Optional RUN-phase write logging is compiled in with `define WRITE_LOG_EN.
module run_scan_checker #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int DATA_W   = 32,
  parameter int CYC_W    = 10,
  parameter int ERR_W    = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CYC_W-1:0]  num_cycles,
  input  logic [REG_AW-1:0] cpu_rs1,
  output logic [REG_AW-1:0] rs1_out,
  input  logic [DATA_W-1:0] reg_data,
  output logic [REG_AW-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              run_active,
  output logic              test_mode,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              first_fail_vld,
  output logic [REG_AW-1:0] first_fail_reg,
  output logic [DATA_W-1:0] first_fail_act,
  input  logic              rwe,
  input  logic [4:0]        rd,
  output logic [CYC_W-1:0]  wr_count,
  output logic [4:0]        last_wr_reg
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_SCAN, S_DRAIN, S_DONE} state_t;

  localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NUM_REGS - 1);

  state_t state_q, state_d;
  logic   accept;

  logic [CYC_W-1:0]  ncyc_q, ncyc_d, cyc_q, cyc_d;
  logic [REG_AW-1:0] scan_idx_q, scan_idx_d, idx_q, idx_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              cmp_v_q, cmp_v_d, mismatch;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              ffv_q, ffv_d;
  logic [REG_AW-1:0] ffreg_q, ffreg_d;
  logic [DATA_W-1:0] ffact_q, ffact_d;
  logic              run_active_q, run_active_d, test_mode_q, test_mode_d;
  logic              done_q, done_d, pass_q, pass_d;

  assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = (num_cycles == '0) ? S_SCAN : S_RUN;
      S_RUN:          if (cyc_q == ncyc_q - CYC_W'(1)) state_d = S_SCAN;
      S_SCAN:         if (scan_idx_q == LAST_IDX) state_d = S_DRAIN;
      S_DRAIN:        state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Compare is one clock behind the read: rd_q holds reg k while the ROM presents entry k.
  assign mismatch = cmp_v_q && (rd_q != exp_data);

  always_comb begin
    ncyc_d     = accept ? num_cycles : ncyc_q;
    cyc_d      = (state_q == S_RUN) ? cyc_q + CYC_W'(1) : '0;
    scan_idx_d = (state_q == S_SCAN) ? scan_idx_q + REG_AW'(1) : '0;
    rd_d       = (state_q == S_SCAN) ? reg_data : rd_q;
    idx_d      = (state_q == S_SCAN) ? scan_idx_q : idx_q;
    cmp_v_d    = (state_q == S_SCAN);
    err_d      = err_q;
    ffv_d      = ffv_q;
    ffreg_d    = ffreg_q;
    ffact_d    = ffact_q;
    if (accept) begin
      err_d   = '0;
      ffv_d   = 1'b0;
      ffreg_d = '0;
      ffact_d = '0;
    end else if (mismatch) begin
      if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
      if (!ffv_q) begin
        ffv_d   = 1'b1;
        ffreg_d = idx_q;
        ffact_d = rd_q;
      end
    end
    run_active_d = (state_q == S_RUN);
    test_mode_d  = (state_q == S_SCAN) || (state_q == S_DRAIN);
    done_d       = (state_q == S_DONE) && !accept;
    pass_d       = (state_q == S_DONE) && !accept && (err_q == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ncyc_q       <= '0;
      cyc_q        <= '0;
      scan_idx_q   <= '0;
      idx_q        <= '0;
      rd_q         <= '0;
      cmp_v_q      <= 1'b0;
      err_q        <= '0;
      ffv_q        <= 1'b0;
      ffreg_q      <= '0;
      ffact_q      <= '0;
      run_active_q <= 1'b0;
      test_mode_q  <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      ncyc_q       <= ncyc_d;
      cyc_q        <= cyc_d;
      scan_idx_q   <= scan_idx_d;
      idx_q        <= idx_d;
      rd_q         <= rd_d;
      cmp_v_q      <= cmp_v_d;
      err_q        <= err_d;
      ffv_q        <= ffv_d;
      ffreg_q      <= ffreg_d;
      ffact_q      <= ffact_d;
      run_active_q <= run_active_d;
      test_mode_q  <= test_mode_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign rs1_out        = (state_q == S_SCAN || state_q == S_DRAIN) ? scan_idx_q : cpu_rs1;
  assign exp_addr       = scan_idx_q;
  assign run_active     = run_active_q;
  assign test_mode      = test_mode_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_reg = ffreg_q;
  assign first_fail_act = ffact_q;

`ifdef WRITE_LOG_EN
  logic [CYC_W-1:0] wr_count_q, wr_count_d;
  logic [4:0]       last_wr_reg_q, last_wr_reg_d;

  always_comb begin
    wr_count_d    = wr_count_q;
    last_wr_reg_d = last_wr_reg_q;
    if (accept) begin
      wr_count_d    = '0;
      last_wr_reg_d = '0;
    end else if (state_q == S_RUN && rwe && rd != 5'd0) begin
      if (wr_count_q != {CYC_W{1'b1}}) wr_count_d = wr_count_q + CYC_W'(1);
      last_wr_reg_d = rd;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_count_q    <= '0;
      last_wr_reg_q <= '0;
    end else begin
      wr_count_q    <= wr_count_d;
      last_wr_reg_q <= last_wr_reg_d;
    end
  end

  assign wr_count    = wr_count_q;
  assign last_wr_reg = last_wr_reg_q;
`else
  logic unused_wr_log;
  assign unused_wr_log = rwe ^ (^rd);
  assign wr_count      = '0;
  assign last_wr_reg   = '0;
`endif

endmodule
